// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: round sequencer for the AES datapath core.
// Walks one block through rounds 0..NR. Each round holds its controls steady
// for an N-cycle window so the core's N-deep feedback chain can carry the
// round result back to its input at the next round's issue cycle (ph==0).
// All control outputs are decoded combinationally from the registered state.
module aes_round_ctrl #(
  parameter int N  = 4,   // feedback chain depth of the core, 1..16
  parameter int NR = 10   // number of rounds, 1..15
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       accept,
  output logic [3:0] rndNo,
  output logic       enbSB,
  output logic       enbSR,
  output logic       enbMC,
  output logic       enbAR,
  output logic       enbKS
);

  // Phase counter needs at least one bit even when N==1.
  localparam int             PW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0]  PH_LAST  = PW'(N - 1);
  localparam logic [3:0]     RND_LAST = 4'(NR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      rnd, rnd_nxt;
  logic [PW-1:0]   ph, ph_nxt;

  // State, round and phase registers; async active-low clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      rnd   <= '0;
      ph    <= '0;
    end else begin
      state <= state_nxt;
      rnd   <= rnd_nxt;
      ph    <= ph_nxt;
    end
  end

  // Next-state sequencing and control decode from the registered state.
  always_comb begin
    state_nxt = state;
    rnd_nxt   = rnd;
    ph_nxt    = ph;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    rndNo     = '0;
    enbSB     = 1'b0;
    enbSR     = 1'b0;
    enbMC     = 1'b0;
    enbAR     = 1'b0;
    enbKS     = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          rnd_nxt   = '0;
          ph_nxt    = '0;
        end
      end

      RUN: begin
        busy  = 1'b1;
        rndNo = rnd;
        if (rnd == '0) begin
          // Round 0: load plain_text/key and do the initial AddRoundKey only.
          accept = 1'b1;
          enbAR  = 1'b1;
        end else begin
          enbSB = 1'b1;
          enbSR = 1'b1;
          enbAR = 1'b1;
          enbKS = 1'b1;
          // The last round skips MixColumns.
          enbMC = (rnd != RND_LAST);
        end

        if (ph == PH_LAST) begin
          ph_nxt = '0;
          if (rnd == RND_LAST) begin
            state_nxt = DONE;
            rnd_nxt   = '0;
          end else begin
            rnd_nxt = rnd + 4'd1;
          end
        end else begin
          ph_nxt = ph + 1'b1;
        end
      end

      DONE: begin
        // cipher_text is final in this cycle; start is ignored here too.
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
        rnd_nxt   = '0;
        ph_nxt    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: three instances (N=4, N=1, N=3, NR=10) run in
// lockstep, each checked cycle by cycle against a cycle-count reference
// model derived from the block's timing rules.
module tb_aes_round_ctrl;

  localparam int NR = 10;
  localparam int ND = 3;
  localparam int NS [ND] = '{4, 1, 3};

  logic          clk = 1'b0;
  logic          rstn;
  logic [ND-1:0] st;
  // {busy, done, accept, rndNo[3:0], enbSB, enbSR, enbMC, enbAR, enbKS}
  logic [11:0]   o [ND];

  int n_checks = 0;
  int n_fail   = 0;
  int done_at [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    logic       busy, done, accept, enbSB, enbSR, enbMC, enbAR, enbKS;
    logic [3:0] rndNo;
    aes_round_ctrl #(.N(NS[g]), .NR(NR)) u_dut (
      .clk    (clk),
      .rstn   (rstn),
      .start  (st[g]),
      .busy   (busy),
      .done   (done),
      .accept (accept),
      .rndNo  (rndNo),
      .enbSB  (enbSB),
      .enbSR  (enbSR),
      .enbMC  (enbMC),
      .enbAR  (enbAR),
      .enbKS  (enbKS)
    );
    assign o[g] = {busy, done, accept, rndNo, enbSB, enbSR, enbMC, enbAR, enbKS};
  end

  // Expected outputs c cycles after the edge that sampled start (c>=1).
  // Cycles 1..(NR+1)*n are RUN, round r = (c-1)/n; cycle (NR+1)*n+1 is DONE.
  function automatic logic [11:0] model(int n, int c);
    int         run_end;
    int         r;
    logic       b, d, acc, sb, sr, mc, ar, ks;
    logic [3:0] rn;
    run_end = (NR + 1) * n;
    {b, d, acc, sb, sr, mc, ar, ks} = '0;
    rn = '0;
    if (c >= 1 && c <= run_end) begin
      r   = (c - 1) / n;
      b   = 1'b1;
      acc = (r == 0);
      rn  = 4'(r);
      ar  = 1'b1;
      sb  = (r > 0);
      sr  = (r > 0);
      ks  = (r > 0);
      mc  = (r > 0) && (r < NR);
    end else if (c == run_end + 1) begin
      b = 1'b1;
      d = 1'b1;
    end
    return {b, d, acc, rn, sb, sr, mc, ar, ks};
  endfunction

  // With start held high, blocks repeat with period (NR+1)*n+2:
  // RUN, one DONE cycle, one IDLE cycle, then the next block.
  function automatic logic [11:0] model_hold(int n, int c);
    int per;
    per = (NR + 1) * n + 2;
    return model(n, ((c - 1) % per) + 1);
  endfunction

  // Present start to all DUTs now (sampled at the next edge, cycle 0 -> 1),
  // then check ncyc cycles. hold keeps start high; otherwise start is random
  // while a block is busy (must be ignored) and 0 afterwards. abort_at>0
  // pulls rstn low inside that cycle and keeps it low.
  task automatic run_seq(input string tag, input int ncyc, input bit hold,
                         input int abort_at);
    logic [11:0] exp;
    st = '1;
    for (int i = 0; i < ND; i++) done_at[i] = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      if (abort_at > 0 && c == abort_at) begin
        #1 rstn = 1'b0;
        #1;
      end
      for (int i = 0; i < ND; i++) begin
        if (abort_at > 0 && c >= abort_at) exp = '0;
        else if (hold)                     exp = model_hold(NS[i], c);
        else                               exp = model(NS[i], c);
        n_checks++;
        if (o[i] !== exp) begin
          n_fail++;
          $display("FAIL %s N=%0d cycle %0d: got %h expected %h", tag, NS[i], c, o[i], exp);
        end
        if (o[i][10] === 1'b1 && done_at[i] == 0) done_at[i] = c;
        if (hold)
          st[i] = 1'b1;
        else if (abort_at == 0 && c <= (NR + 1) * NS[i] + 1)
          st[i] = 1'($urandom_range(1, 0));
        else
          st[i] = 1'b0;
      end
    end
    st = '0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    st   = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < ND; i++) begin
        n_checks++;
        if (o[i] !== 12'h000) begin
          n_fail++;
          $display("FAIL reset N=%0d: got %h expected 000", NS[i], o[i]);
        end
      end
    end
    release_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < ND; i++) begin
        n_checks++;
        if (o[i] !== 12'h000) begin
          n_fail++;
          $display("FAIL idle N=%0d: got %h expected 000", NS[i], o[i]);
        end
      end
    end
  endtask

  // Single block on every DUT, with random start noise while busy; also
  // checks the absolute done cycle for each depth (N=4:45, N=1:12, N=3:34).
  task automatic test_single_block();
    int gap;
    gap = $urandom_range(4, 0);
    repeat (gap) @(posedge clk);
    #1;
    run_seq("single", 50, 1'b0, 0);
    for (int i = 0; i < ND; i++) begin
      n_checks++;
      if (done_at[i] !== (NR + 1) * NS[i] + 1) begin
        n_fail++;
        $display("FAIL done_cycle N=%0d: got %0d expected %0d", NS[i], done_at[i],
                 (NR + 1) * NS[i] + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int busy_low;
    run_seq("b2b", 100, 1'b1, 0);
    // Leave the held-start stream cleanly: reset, then idle.
    rstn = 1'b0;
    @(posedge clk);
    release_reset();
    // Busy must drop for exactly one cycle between held-start blocks (N=4).
    busy_low = 0;
    st = '1;
    for (int c = 1; c <= 47; c++) begin
      @(posedge clk);
      #1;
      if (o[0][11] === 1'b0) busy_low++;
    end
    st = '0;
    n_checks++;
    if (busy_low !== 1) begin
      n_fail++;
      $display("FAIL b2b_busy_gap: got %0d idle cycles expected 1", busy_low);
    end
    rstn = 1'b0;
    @(posedge clk);
    release_reset();
  endtask

  task automatic test_abort();
    run_seq("abort", 26, 1'b0, 20);
    release_reset();
    for (int i = 0; i < ND; i++) begin
      n_checks++;
      if (o[i] !== 12'h000) begin
        n_fail++;
        $display("FAIL abort_idle N=%0d: got %h expected 000", NS[i], o[i]);
      end
    end
    // Fresh block after the abort must run to completion normally.
    run_seq("after_abort", 48, 1'b0, 0);
    n_checks++;
    if (done_at[0] !== 45) begin
      n_fail++;
      $display("FAIL after_abort_done: got %0d expected 45", done_at[0]);
    end
  endtask

  initial begin
    rstn = 1'b0;
    st   = '0;
    test_reset();
    test_single_block();
    test_back_to_back();
    test_abort();
    test_single_block();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
